// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the register file's single write port between two writeback sources.
// It also keeps a per-register pending-write scoreboard that drives the
// decode stall logic.
//   Port 0 : single-cycle ALU results. Normally has priority.
//   Port 1 : long-latency results (load, mul/div). After STARVE_LIMIT
//            consecutive losses it is boosted and wins the next arbitration.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req0_valid/ready/addr/data   ALU writeback request (ready combinational)
//   req1_valid/ready/addr/data   long-latency writeback request (ready comb.)
//   issue_valid, issue_addr      long-latency op issued; marks addr pending
//   chk_addr1, chk_addr2         decode source operands to check
//   hazard                       a checked source is pending (combinational)
//   wr_en, wr_addr, wr_data      register file write port (registered)
//   busy_vec                     scoreboard, bit i = write to ri pending
//   issue_err                    one-cycle pulse: issue to an already-busy reg
module rf_wb_arbiter #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_addr,
  input  logic [AW-1:0]   chk_addr1,
  input  logic [AW-1:0]   chk_addr2,
  output logic            hazard,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic [NREG-1:0] busy_vec,
  output logic            issue_err
);

  typedef enum logic [0:0] {
    NORMAL = 1'b0,
    BOOST  = 1'b1
  } mode_t;

  localparam logic [3:0]      LP_LIMIT  = 4'(STARVE_LIMIT);
  localparam logic [AW-1:0]   LP_ZERO_A = {AW{1'b0}};
  localparam logic [NREG-1:0] LP_ONE_V  = {{(NREG-1){1'b0}}, 1'b1};

  // One-hot decode of a register address into a scoreboard mask.
  function automatic logic [NREG-1:0] f_dec(input logic [AW-1:0] a);
    f_dec = LP_ONE_V << a;
  endfunction

  mode_t           r_mode;
  mode_t           w_mode_nxt;
  logic [3:0]      r_starve;
  logic [3:0]      w_starve_nxt;

  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic [NREG-1:0] r_busy;
  logic            r_issue_err;

  logic            w_acc0;
  logic            w_acc1;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;
  logic            w_do_write;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_err_nxt;

  // Arbitration mode register and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode   <= NORMAL;
      r_starve <= 4'd0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  // Grant decode plus next mode and next starvation count.
  always_comb begin
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    w_mode_nxt   = r_mode;
    w_starve_nxt = r_starve;

    case (r_mode)
      NORMAL: begin
        req0_ready = req0_valid;
        req1_ready = req1_valid & ~req0_valid;
      end
      BOOST: begin
        req0_ready = 1'b0;
        req1_ready = req1_valid;
      end
      default: begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
      end
    endcase

    if (req1_valid && req1_ready) begin
      w_starve_nxt = 4'd0;
      w_mode_nxt   = NORMAL;
    end else if (!req1_valid) begin
      // The protocol keeps valid high until acceptance, so this path is only
      // reached outside BOOST. Falling back to NORMAL means port 0 can never
      // be locked out if a requester misbehaves.
      w_starve_nxt = 4'd0;
      w_mode_nxt   = NORMAL;
    end else begin
      // A port 1 loss can only happen in NORMAL, because BOOST always grants it.
      w_starve_nxt = r_starve + 4'd1;
      if (w_starve_nxt == LP_LIMIT) begin
        w_mode_nxt = BOOST;
      end else begin
        w_mode_nxt = r_mode;
      end
    end
  end

  // Select the accepted transfer. The two grants never overlap.
  always_comb begin
    w_acc0 = req0_valid & req0_ready;
    w_acc1 = req1_valid & req1_ready;
    if (w_acc1) begin
      w_sel_addr = req1_addr;
      w_sel_data = req1_data;
    end else begin
      w_sel_addr = req0_addr;
      w_sel_data = req0_data;
    end
    // r0 is hardwired zero. The transfer is accepted, but nothing is written.
    w_do_write = (w_acc0 | w_acc1) & (w_sel_addr != LP_ZERO_A);
  end

  // Register file write port. Address and data hold while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_addr <= LP_ZERO_A;
      r_wr_data <= {DW{1'b0}};
    end else begin
      r_wr_en <= w_do_write;
      if (w_do_write) begin
        r_wr_addr <= w_sel_addr;
        r_wr_data <= w_sel_data;
      end
    end
  end

  // Scoreboard next state. A set on the same edge as a clear wins.
  always_comb begin
    w_set = {NREG{1'b0}};
    w_clr = {NREG{1'b0}};
    if (issue_valid && (issue_addr != LP_ZERO_A)) begin
      w_set = f_dec(issue_addr);
    end else begin
      w_set = {NREG{1'b0}};
    end
    if (w_acc1) begin
      w_clr = f_dec(req1_addr);
    end else begin
      w_clr = {NREG{1'b0}};
    end
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~LP_ONE_V;
    // Reissuing to a register that stays busy is flagged. A register that
    // is cleared on the same edge was legitimately freed first.
    w_err_nxt  = issue_valid & (issue_addr != LP_ZERO_A) & r_busy[issue_addr]
               & ~(w_acc1 & (req1_addr == issue_addr));
  end

  // Scoreboard and issue error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= {NREG{1'b0}};
      r_issue_err <= 1'b0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_issue_err <= w_err_nxt;
    end
  end

  // Hazard comes from registered state only. busy[0] is always 0, so reads
  // of r0 never stall.
  assign hazard    = r_busy[chk_addr1] | r_busy[chk_addr2];
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy_vec  = r_busy;
  assign issue_err = r_issue_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req0_ready;
  logic [AW-1:0]   req0_addr;
  logic [DW-1:0]   req0_data;
  logic            req1_valid, req1_ready;
  logic [AW-1:0]   req1_addr;
  logic [DW-1:0]   req1_data;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic [AW-1:0]   chk_addr1, chk_addr2;
  logic            hazard;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [NREG-1:0] busy_vec;
  logic            issue_err;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  logic [NREG-1:0]  exp_busy;

  rf_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .hazard(hazard), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_vec(busy_vec), .issue_err(issue_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Moves to the next cycle. An expected write is queued at the accepting edge.
  task automatic advance(input logic push, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(posedge clk);
    if (push) exp_q.push_back({a, d});
    #1;
  endtask

  task automatic idle();
    req0_valid  = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid  = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    issue_valid = 1'b0; issue_addr = 5'd0;
    chk_addr1   = 5'd0; chk_addr2 = 5'd0;
  endtask

  // Monitor: each register file write is matched against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {63'd0, wr_en}, 64'd0);
      end else begin
        logic [AW+DW-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr", {59'd0, wr_addr}, {59'd0, e[AW+DW-1:DW]});
        check("wr_data", {32'd0, wr_data}, {32'd0, e[DW-1:0]});
      end
    end
  end

  initial begin
    idle();
    rst = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h22;
    issue_valid = 1'b1; issue_addr = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    @(negedge clk);
    check("rst_wr_en", {63'd0, wr_en}, 64'd0);
    check("rst_busy", {32'd0, busy_vec}, 64'd0);
    check("rst_issue_err", {63'd0, issue_err}, 64'd0);
    advance(1'b0, 5'd0, 32'd0);

    // Port 0 priority, then port 1 gets the following cycle.
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAB;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h44;
    @(negedge clk);
    check("prio_r0", {63'd0, req0_ready}, 64'd1);
    check("prio_r1", {63'd0, req1_ready}, 64'd0);
    advance(1'b1, 5'd3, 32'hAB);
    req0_valid = 1'b0;
    @(negedge clk);
    check("after_r1", {63'd0, req1_ready}, 64'd1);
    advance(1'b1, 5'd4, 32'h44);
    idle();
    advance(1'b0, 5'd0, 32'd0);

    // Starvation: four port 0 wins, port 1 on the fifth, then port 0 again.
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    for (int k = 0; k < 6; k++) begin
      logic g1;
      g1 = (k == 4);
      req0_valid = 1'b1; req0_addr = 5'(10 + k); req0_data = 32'(k + 16);
      @(negedge clk);
      check("starve_r0", {63'd0, req0_ready}, {63'd0, ~g1});
      check("starve_r1", {63'd0, req1_ready}, {63'd0, g1});
      if (g1) advance(1'b1, 5'd6, 32'h66);
      else    advance(1'b1, 5'(10 + k), 32'(k + 16));
      if (g1) req1_valid = 1'b0;
    end
    idle();
    advance(1'b0, 5'd0, 32'd0);

    // Scoreboard lifecycle on r7.
    issue_valid = 1'b1; issue_addr = 5'd7; chk_addr1 = 5'd7;
    @(negedge clk);
    check("no_bypass_hazard", {63'd0, hazard}, 64'd0);
    advance(1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0;
    @(negedge clk);
    check("busy7_set", {32'd0, busy_vec}, 64'h80);
    check("hazard7", {63'd0, hazard}, 64'd1);
    advance(1'b0, 5'd0, 32'd0);
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h77;
    @(negedge clk);
    check("r1_ready7", {63'd0, req1_ready}, 64'd1);
    advance(1'b1, 5'd7, 32'h77);
    req1_valid = 1'b0;
    @(negedge clk);
    check("hazard7_clr", {63'd0, hazard}, 64'd0);
    check("wr_en7", {63'd0, wr_en}, 64'd1);
    check("busy7_clr", {32'd0, busy_vec}, 64'd0);
    advance(1'b0, 5'd0, 32'd0);

    // Set and clear of r9 on the same edge: the set wins, with no error.
    issue_valid = 1'b1; issue_addr = 5'd9;
    advance(1'b0, 5'd0, 32'd0);
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    @(negedge clk);
    check("r1_ready9", {63'd0, req1_ready}, 64'd1);
    advance(1'b1, 5'd9, 32'h99);
    idle();
    exp_busy = 32'h200;
    @(negedge clk);
    check("busy9_setwins", {32'd0, busy_vec}, {32'd0, exp_busy});
    check("err9", {63'd0, issue_err}, 64'd0);
    advance(1'b0, 5'd0, 32'd0);

    // r0 handling.
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hFF;
    issue_valid = 1'b1; issue_addr = 5'd0;
    @(negedge clk);
    check("r0_ready", {63'd0, req0_ready}, 64'd1);
    advance(1'b0, 5'd0, 32'd0);
    idle();
    chk_addr1 = 5'd0; chk_addr2 = 5'd0;
    @(negedge clk);
    check("r0_wr_en", {63'd0, wr_en}, 64'd0);
    check("r0_busy", {32'd0, busy_vec}, {32'd0, exp_busy});
    check("r0_hazard", {63'd0, hazard}, 64'd0);
    check("r0_err", {63'd0, issue_err}, 64'd0);
    chk_addr2 = 5'd9;
    #1;
    check("hazard9", {63'd0, hazard}, 64'd1);
    advance(1'b0, 5'd0, 32'd0);

    // Two issues to r12 with no writeback: exactly one error pulse.
    idle();
    issue_valid = 1'b1; issue_addr = 5'd12;
    advance(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("err12_first", {63'd0, issue_err}, 64'd0);
    advance(1'b0, 5'd0, 32'd0);
    issue_valid = 1'b0;
    @(negedge clk);
    check("err12_pulse", {63'd0, issue_err}, 64'd1);
    exp_busy = 32'h1200;
    check("busy12", {32'd0, busy_vec}, {32'd0, exp_busy});
    advance(1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("err12_end", {63'd0, issue_err}, 64'd0);

    repeat (3) advance(1'b0, 5'd0, 32'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Arbitrates the register file's single write port between two writeback sources.
  - Port 0: single-cycle ALU result.
  - Port 1: long-latency result, e.g. load or mul/div.
- Keeps a per-register pending-write scoreboard and flags read hazards to the decode/stall logic.
- Sits between the execute/memory stages and the register file write inputs (write enable, write address, write data).

Parameters:
- NREG, 32, number of architectural registers; must equal 2**AW.
- AW, 5, register address width.
- DW, 32, data width.
- STARVE_LIMIT, 4, consecutive lost arbitrations on port 1 before port 1 is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  ALU writeback request.
- req0_ready  out  1  port 0 granted this cycle (combinational).
- req0_addr  in  AW  destination register.
- req0_data  in  DW  result.
- req1_valid  in  1  long-latency writeback request.
- req1_ready  out  1  port 1 granted this cycle (combinational).
- req1_addr  in  AW  destination register.
- req1_data  in  DW  result.
- issue_valid  in  1  a long-latency op targeting issue_addr is issued; marks the register pending.
- issue_addr  in  AW  pending destination.
- chk_addr1  in  AW  decode source operand 1.
- chk_addr2  in  AW  decode source operand 2.
- hazard  out  1  a checked source is pending (combinational).
- wr_en  out  1  register file write enable (registered).
- wr_addr  out  AW  register file write address (registered).
- wr_data  out  DW  register file write data (registered).
- busy_vec  out  NREG  scoreboard bits; bit i set means a write to ri is pending.
- issue_err  out  1  one-cycle pulse: issue to an already-busy register.

Behaviour:
- Reset:
  - wr_en=0, wr_addr=0, wr_data=0.
  - busy_vec=0, issue_err=0, starve counter=0, mode=NORMAL.
  - rst wins over every same-cycle event; in-flight requests are dropped, not replayed.
  - req*_ready are still computed combinationally during reset but have no effect.
- Handshake:
  - A transfer occurs when valid && ready at a clock edge.
  - At most one ready is high per cycle.
  - ready never depends on ready; a requester may not drop valid or change addr/data until accepted.
- Arbitration, mode NORMAL:
  - Port 0 has priority: req0_ready=req0_valid.
  - req1_ready=req1_valid && !req0_valid.
- Arbitration, mode BOOST:
  - req1_ready=req1_valid; req0_ready=0.
- Starve counter (4 bits):
  - Increments on each edge where req1_valid && !req1_ready.
  - Clears on a port 1 grant, or when req1_valid=0.
  - When the counter equals STARVE_LIMIT, mode=BOOST for the next cycle.
  - Leaving BOOST: a port 1 grant returns the mode to NORMAL and clears the counter.
- Write path:
  - One-cycle latency: accepted addr/data appear on wr_addr/wr_data at the next edge, with wr_en=1.
  - wr_en=0 in any cycle following an edge with no accepted transfer; wr_addr/wr_data hold their last values.
  - r0 is hardwired zero: a transfer with addr 0 is accepted (ready asserted normally) but produces wr_en=0.
- Scoreboard:
  - issue_valid with issue_addr!=0 sets busy[issue_addr] at the edge.
  - issue_addr=0 is ignored.
  - A port 1 transfer clears busy[req1_addr] at the acceptance edge, so hazard drops in the same cycle wr_en rises.
  - Port 0 transfers never modify busy.
  - Same edge, same address, set and clear together: the set wins (a new op is pending).
  - issue_valid to an address already busy (and not cleared on that edge): busy stays 1 and issue_err pulses high for exactly one cycle. WAW depth is not tracked.
  - busy[0] is constant 0.
- Hazard:
  - hazard = busy[chk_addr1] | busy[chk_addr2], from current register state.
  - No bypass from same-cycle issue.
  - Reads of r0 never raise a hazard.

Test Plan:
- Reset behaviour: assert rst for 2 cycles while req0_valid=1, req1_valid=1, issue_valid=1 with issue_addr=5 -> wr_en=0, busy_vec=0, issue_err=0 on the cycle after release.
- Port 0 priority and latency: req0 (addr 3, data 32'hAB) and req1 (addr 4) both valid -> req0_ready=1, req1_ready=0; next cycle wr_en=1, wr_addr=3, wr_data=32'hAB.
- Starvation: req0_valid and req1_valid held high continuously, STARVE_LIMIT=4 -> port 0 wins 4 cycles, port 1 wins the 5th, then port 0 resumes.
- Scoreboard lifecycle:
  - issue_addr=7 -> busy_vec[7]=1 next cycle.
  - chk_addr1=7 -> hazard=1.
  - req1 accepted to addr 7 -> busy clears at that edge; the next cycle shows hazard=0 with wr_en=1, wr_addr=7.
- Simultaneous set/clear: issue_addr=9 on the same edge that req1 to addr 9 is accepted -> busy_vec[9]=1, issue_err=0.
- r0 handling:
  - req0 to addr 0 with data 32'hFF -> req0_ready=1, next cycle wr_en=0.
  - issue_addr=0 -> busy_vec unchanged.
  - chk_addr1=0 -> hazard=0.
  - issue to addr 12 twice without writeback -> issue_err pulses once, on the cycle after the second issue.
